problem_1a: RTL and testbench
=============================

PROBLEM_1A -- requirements
Module: problem1A

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 W  input  1  operand bit 3 (MSB) of 4-bit value N.
REQ-005 X  input  1  operand bit 2 of N.
REQ-006 Y  input  1  operand bit 1 of N.
REQ-007 Z  input  1  operand bit 0 (LSB) of N.
REQ-008 E  output  1  registered flag: N is prime.
REQ-009 F  output  1  registered flag: N is a multiple of 3.
REQ-010 The block SHALL use exactly one clock; reset SHALL be asynchronous and active-low.

Function
REQ-011 N SHALL be formed as {W,X,Y,Z}, unsigned, range 0..15.
REQ-012 The E next-state SHALL be 1 exactly for N in {2,3,5,7,11,13}, else 0; 0 and 1 are not prime.
REQ-013 The F next-state SHALL be 1 exactly for N in {0,3,6,9,12,15}, else 0; 0 counts as a multiple of 3.
REQ-014 The block SHALL sample W, X, Y and Z on each rising clk edge while rst_n is high.
REQ-015 E and F SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-016 Latency SHALL be exactly one cycle: outputs after edge k reflect the N sampled at edge k.
REQ-017 Outputs SHALL hold their value between rising edges regardless of input changes.
REQ-018 There SHALL be no enable, handshake or back-pressure; a new result is produced every cycle.
REQ-019 E and F SHALL both be 1 for N=3 only, and both 0 for N in {1,4,8,10,14}.
REQ-020 Inputs SHALL be treated as synchronous to clk; the block SHALL contain no synchronizers.
REQ-021 Unknown or X inputs SHALL NOT be specially handled; behaviour with X inputs is undefined.

Reset
REQ-022 Asserting rst_n low SHALL force E=0 and F=0 immediately, without waiting for a clock edge.
REQ-023 While rst_n is low, E and F SHALL remain 0 and input changes SHALL have no effect.
REQ-024 The first rising edge after rst_n goes high SHALL sample inputs normally; no extra warm-up cycles.
REQ-025 Reset asserted mid-operation SHALL discard the current result; no prior value is retained after release.

Verification
REQ-026 Reset: hold rst_n=0, apply N=3, toggle clk several edges -> E=0, F=0 throughout.
REQ-027 Exhaustive sweep: after reset release, apply N=0..15, one value per cycle, with inputs changed away from clk edges -> the outputs one edge later SHALL be:
  N:  0  1  2  3  4  5  6  7  8  9  10 11 12 13 14 15
  E:  0  0  1  1  0  1  0  1  0  0  0  1  0  1  0  0
  F:  1  0  0  1  0  0  1  0  0  1  0  0  1  0  0  1
REQ-028 Latency/hold: apply N=5 before edge k, then change to N=6 mid-cycle -> E=1, F=0 until edge k+1, then E=0, F=1.
REQ-029 Async reset mid-run: with N=13 registered (E=1, F=0), drop rst_n between edges -> E=0, F=0 immediately, before any clk edge.
REQ-030 Reset release: release rst_n with N=15 applied -> E=0, F=0 until the first rising edge, then E=0, F=1.
REQ-031 Back-to-back: alternate N=3 and N=8 every cycle for 8 cycles -> (E,F) alternates (1,1) and (0,0) with one-cycle lag.

Source files
------------

// File: rtl/problem_1a_if.sv
// Operand/result bundle for problem_1a: four operand bits forming N, two registered flags.
interface problem_1a_if;
  logic W;
  logic X;
  logic Y;
  logic Z;
  logic E;
  logic F;

  modport master (output W, X, Y, Z, input E, F);
  modport slave  (input W, X, Y, Z, output E, F);
endinterface

// File: rtl/problem_1a.sv
// Registered classifier of a 4-bit value N={W,X,Y,Z}: E flags N prime, F flags N a multiple of 3.
module problem_1a (
  input  logic         clk,
  input  logic         rst_n,
  problem_1a_if.slave  bus
);

  // Bit k of each mask is the flag value for N == k.
  localparam logic [15:0] PRIME_MASK = 16'h28AC;  // {2,3,5,7,11,13}
  localparam logic [15:0] MULT3_MASK = 16'h9249;  // {0,3,6,9,12,15}

  logic [3:0] n;
  logic       e_d, e_q;
  logic       f_d, f_q;

  assign n = {bus.W, bus.X, bus.Y, bus.Z};

  always_comb begin
    e_d = PRIME_MASK[n];
    f_d = MULT3_MASK[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= 1'b0;
      f_q <= 1'b0;
    end else begin
      e_q <= e_d;
      f_q <= f_d;
    end
  end

  assign bus.E = e_q;
  assign bus.F = f_q;

endmodule

// File: tb/tb_problem_1a.sv
// Bench for problem_1a: arithmetic reference model checked every cycle plus directed literal checks.
module tb_problem_1a;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   model_on;
  logic me, mf;

  problem_1a_if bus ();

  problem_1a dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic bit is_prime(int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d < v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_mult3(int v);
    return (v % 3) == 0;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got E,F=%b required %b", name, $time, act, exp);
    end
  endtask

  task automatic set_n(input int v);
    logic [3:0] b;
    b = v[3:0];
    bus.W = b[3];
    bus.X = b[2];
    bus.Y = b[1];
    bus.Z = b[0];
  endtask

  // Reference model: value of the flags as of the most recent edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me <= 1'b0;
      mf <= 1'b0;
    end else begin
      me <= is_prime({bus.W, bus.X, bus.Y, bus.Z});
      mf <= is_mult3({bus.W, bus.X, bus.Y, bus.Z});
    end
  end

  always @(negedge clk) begin
    if (model_on) chk("model", {bus.E, bus.F}, {me, mf});
  end

  logic [15:0] e_tab;
  logic [15:0] f_tab;

  initial begin
    checks   = 0;
    errors   = 0;
    model_on = 1'b0;
    e_tab    = 16'b0010_1000_1010_1100;
    f_tab    = 16'b1001_0010_0100_1001;
    rst_n    = 1'b0;
    set_n(3);

    // Held in reset with N=3 applied.
    repeat (4) begin
      @(negedge clk);
      chk("reset_hold", {bus.E, bus.F}, 2'b00);
    end
    model_on = 1'b1;

    // Exhaustive sweep.
    set_n(0);
    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) begin
      set_n(v);
      @(negedge clk);
      chk($sformatf("sweep_n%0d", v), {bus.E, bus.F}, {e_tab[v], f_tab[v]});
    end

    // Latency/hold: 5 registered, input moves to 6 mid-cycle.
    set_n(5);
    @(posedge clk);
    #2;
    chk("hold_after_k", {bus.E, bus.F}, 2'b10);
    #1 set_n(6);
    #1 chk("hold_mid", {bus.E, bus.F}, 2'b10);
    @(posedge clk);
    #1 chk("next_edge", {bus.E, bus.F}, 2'b01);

    // Asynchronous reset mid-run with 13 registered.
    @(negedge clk);
    set_n(13);
    @(posedge clk);
    #2 chk("n13_reg", {bus.E, bus.F}, 2'b10);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {bus.E, bus.F}, 2'b00);

    // Release with 15 applied.
    set_n(15);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("release_pre", {bus.E, bus.F}, 2'b00);
    @(posedge clk);
    #1 chk("release_first", {bus.E, bus.F}, 2'b01);

    // Back-to-back 3/8 alternation.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_n((i % 2 == 0) ? 3 : 8);
      @(negedge clk);
      chk($sformatf("alt_%0d", i), {bus.E, bus.F}, (i % 2 == 0) ? 2'b11 : 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      set_n((i % 2 == 0) ? 3 : 8);
      @(negedge clk);
      chk($sformatf("alt_b2b_%0d", i), {bus.E, bus.F}, (i % 2 == 0) ? 2'b11 : 2'b00);
    end

    @(negedge clk);
    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
